// File: rtl/asrv32_dbus_if.sv
// Data-bus channel between asrv32_dbus_master and a memory responder.
// Signal names keep the master's point of view (o_ = driven by master).
interface asrv32_dbus_if;
  logic        o_stb;
  logic        o_we;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [3:0]  o_wr_mask;
  logic        i_ack;
  logic [31:0] i_rdata;

  modport master (
    output o_stb, o_we, o_addr, o_wdata, o_wr_mask,
    input  i_ack, i_rdata
  );

  modport slave (
    input  o_stb, o_we, o_addr, o_wdata, o_wr_mask,
    output i_ack, i_rdata
  );
endinterface

// File: rtl/asrv32_dbus_master.sv
// Load/store data-bus master: one strobe per access, lane steering and load extension.
// Optional ack timeout enabled by defining ASRV32_DBUS_TIMEOUT_EN.
module asrv32_dbus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_funct3,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_bus_err,
  asrv32_dbus_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_STB, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [1:0]  r_off;
  logic [2:0]  r_funct3;
  logic        r_mis;
  logic [31:0] r_rdata;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_mask;
  logic        w_accept;
  logic        w_req_mis;
  logic        w_ack;
  logic        w_timeout;
  logic [31:0] w_store_data;
  logic [3:0]  w_store_mask;
  logic [31:0] w_shift;
  logic [31:0] w_load_data;

  assign w_accept  = (r_state == S_IDLE) && i_req;
  assign w_req_mis = i_funct3[1] ? (i_addr[1:0] != 2'b00) : (i_funct3[0] & i_addr[0]);
  assign w_ack     = (r_state == S_WAIT) && bus.i_ack;

`ifdef ASRV32_DBUS_TIMEOUT_EN
  logic [31:0] r_cnt;
  logic        r_err;

  assign w_timeout = (r_state == S_WAIT) && !bus.i_ack && (r_cnt == TIMEOUT_CYCLES - 1);

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + 32'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign o_bus_err = (r_state == S_RESP) && r_err;
`else
  assign w_timeout = 1'b0;
  assign o_bus_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_req) w_next = w_req_mis ? S_RESP : S_STB;
      S_STB:  w_next = S_WAIT;
      S_WAIT: if (w_ack || w_timeout) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_store_data = i_wdata;
    w_store_mask = 4'b1111;
    case (i_funct3[1:0])
      2'b00: begin
        w_store_data = {4{i_wdata[7:0]}};
        w_store_mask = 4'b0001 << i_addr[1:0];
      end
      2'b01: begin
        w_store_data = {2{i_wdata[15:0]}};
        w_store_mask = 4'b0011 << i_addr[1:0];
      end
      default: ;
    endcase
  end

  // Offset and width come from the latched request, not the live core inputs.
  always_comb begin
    w_shift     = bus.i_rdata >> {r_off, 3'b000};
    w_load_data = w_shift;
    case (r_funct3[1:0])
      2'b00:   w_load_data = {{24{~r_funct3[2] & w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_load_data = {{16{~r_funct3[2] & w_shift[15]}}, w_shift[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_off       <= '0;
      r_funct3    <= '0;
      r_mis       <= 1'b0;
      r_rdata     <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_mask  <= '0;
    end else if (w_accept) begin
      r_we        <= i_we;
      r_off       <= i_addr[1:0];
      r_funct3    <= i_funct3;
      r_mis       <= w_req_mis;
      r_rdata     <= '0;
      r_bus_addr  <= {i_addr[31:2], 2'b00};
      r_bus_wdata <= w_store_data;
      r_bus_mask  <= i_we ? w_store_mask : 4'b0000;
    end else if (w_ack) begin
      r_rdata <= r_we ? 32'd0 : w_load_data;
    end else if (w_timeout) begin
      r_rdata <= '0;
    end
  end

  always_comb begin
    o_busy        = (r_state != S_IDLE);
    o_done        = (r_state == S_RESP);
    o_misaligned  = (r_state == S_RESP) && r_mis;
    o_rdata       = (r_state == S_RESP) ? r_rdata : 32'd0;
    bus.o_stb     = (r_state == S_STB);
    bus.o_we      = (r_state == S_STB) && r_we;
    bus.o_addr    = r_bus_addr;
    bus.o_wdata   = r_bus_wdata;
    bus.o_wr_mask = r_bus_mask;
  end

endmodule

// File: tb/tb_asrv32_dbus_master.sv
// Self-checking bench for asrv32_dbus_master with a byte-lane reference model.
module tb_asrv32_dbus_master;

  logic        i_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [2:0]  i_funct3 = '0;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_misaligned;
  logic        o_bus_err;
  int          total = 0;
  int          bad = 0;

  asrv32_dbus_if bus ();

  asrv32_dbus_master #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk        (i_clk),
    .rst_n        (rst_n),
    .i_req        (i_req),
    .i_we         (i_we),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_funct3     (i_funct3),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rdata      (o_rdata),
    .o_misaligned (o_misaligned),
    .o_bus_err    (o_bus_err),
    .bus          (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] f3);
    return f3[1] ? 4 : (f3[0] ? 2 : 1);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
    int unsigned n;
    int unsigned off;
    longint unsigned v;
    logic [7:0] lanes [4];
    n = acc_size(f3);
    off = addr % 4;
    v = 0;
    for (int i = 0; i < 4; i++) lanes[i] = word[8*i +: 8];
    for (int unsigned k = 0; k < n; k++) v += 64'(lanes[off+k]) << (8*k);
    if (!f3[2] && n < 4 && lanes[off+n-1][7]) v += 64'h1_0000_0000 - (64'd1 << (8*n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wdata, input logic [2:0] f3);
    logic [31:0] r;
    int unsigned n;
    n = acc_size(f3);
    for (int unsigned k = 0; k < 4; k++) r[8*k +: 8] = wdata[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] model_mask(input logic [31:0] addr, input logic [2:0] f3);
    logic [3:0] m;
    int unsigned n;
    int unsigned off;
    n = acc_size(f3);
    off = addr % 4;
    for (int unsigned k = 0; k < 4; k++) m[k] = (k >= off) && (k < off + n);
    return m;
  endfunction

  // Starts at a falling edge with the DUT idle; ends at the falling edge of the next accept slot.
  task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input logic [31:0] rdata, input int unsigned delay, input logic stale);
    logic        mis;
    logic [31:0] exp_rd;
    logic [31:0] exp_addr;
    mis      = (addr % acc_size(f3)) != 0;
    exp_rd   = (we || mis) ? 32'd0 : model_load(rdata, addr, f3);
    exp_addr = {addr[31:2], 2'b00};
    i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata; i_funct3 = f3;
    @(negedge i_clk);
    i_req = 1'b1; i_we = 1'($urandom); i_addr = $urandom; i_wdata = $urandom; i_funct3 = 3'($urandom);
    if (mis) begin
      check({tag, ":mis_stb"}, 32'(bus.o_stb), 0);
      check({tag, ":mis_done"}, 32'(o_done), 1);
      check({tag, ":mis_flag"}, 32'(o_misaligned), 1);
      check({tag, ":mis_err"}, 32'(o_bus_err), 0);
      @(negedge i_clk);
      i_req = 1'b0;
      check({tag, ":mis_after_done"}, 32'(o_done), 0);
      check({tag, ":mis_after_busy"}, 32'(o_busy), 0);
      return;
    end
    check({tag, ":stb"}, 32'(bus.o_stb), 1);
    check({tag, ":stb_we"}, 32'(bus.o_we), 32'(we));
    check({tag, ":addr"}, bus.o_addr, exp_addr);
    check({tag, ":busy"}, 32'(o_busy), 1);
    check({tag, ":stb_done"}, 32'(o_done), 0);
    if (we) begin
      check({tag, ":wdata"}, bus.o_wdata, model_wdata(wdata, f3));
      check({tag, ":mask"}, 32'(bus.o_wr_mask), 32'(model_mask(addr, f3)));
    end
    if (stale) begin
      bus.i_ack = 1'b1; bus.i_rdata = ~rdata;
    end
    repeat (delay) begin
      @(negedge i_clk);
      bus.i_ack = 1'b0;
      check({tag, ":wait_stb"}, 32'(bus.o_stb), 0);
      check({tag, ":wait_we"}, 32'(bus.o_we), 0);
      check({tag, ":wait_done"}, 32'(o_done), 0);
      check({tag, ":wait_addr"}, bus.o_addr, exp_addr);
    end
    @(negedge i_clk);
    bus.i_ack = 1'b1; bus.i_rdata = rdata; i_req = 1'b0;
    check({tag, ":ack_stb"}, 32'(bus.o_stb), 0);
    check({tag, ":ack_done"}, 32'(o_done), 0);
    check({tag, ":ack_addr"}, bus.o_addr, exp_addr);
    if (we) check({tag, ":ack_wdata"}, bus.o_wdata, model_wdata(wdata, f3));
    @(negedge i_clk);
    bus.i_ack = 1'b0; bus.i_rdata = $urandom;
    check({tag, ":done"}, 32'(o_done), 1);
    check({tag, ":rdata"}, o_rdata, exp_rd);
    check({tag, ":done_mis"}, 32'(o_misaligned), 0);
    check({tag, ":done_err"}, 32'(o_bus_err), 0);
    check({tag, ":done_we"}, 32'(bus.o_we), 0);
    @(negedge i_clk);
    check({tag, ":idle_done"}, 32'(o_done), 0);
    check({tag, ":idle_busy"}, 32'(o_busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":busy"}, 32'(o_busy), 0);
    check({tag, ":done"}, 32'(o_done), 0);
    check({tag, ":rdata"}, o_rdata, 0);
    check({tag, ":mis"}, 32'(o_misaligned), 0);
    check({tag, ":err"}, 32'(o_bus_err), 0);
    check({tag, ":stb"}, 32'(bus.o_stb), 0);
    check({tag, ":we"}, 32'(bus.o_we), 0);
    check({tag, ":addr"}, bus.o_addr, 0);
    check({tag, ":wdata"}, bus.o_wdata, 0);
    check({tag, ":mask"}, 32'(bus.o_wr_mask), 0);
  endtask

  initial begin
    int unsigned cyc;
    logic        got;
    logic [31:0] rd;
    bus.i_ack = 1'b0;
    bus.i_rdata = '0;
    #1;
    check_all_zero("reset");
    @(negedge i_clk);
    rst_n = 1'b1;
    @(negedge i_clk);

    run_txn("lw_10", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0, 1'b0);
    run_txn("lb_13", 1'b0, 32'h13, 32'h0, 3'b000, 32'h80FF1234, 0, 1'b0);
    run_txn("lbu_13", 1'b0, 32'h13, 32'h0, 3'b100, 32'h80FF1234, 0, 1'b0);
    run_txn("sh_22", 1'b1, 32'h22, 32'h0000ABCD, 3'b001, 32'h12345678, 0, 1'b0);
    run_txn("lw_05", 1'b0, 32'h05, 32'h0, 3'b010, 32'h0, 0, 1'b0);
    run_txn("lh_stale", 1'b0, 32'h102, 32'h0, 3'b001, 32'h8001_7FFF, 2, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic        we;
      logic [31:0] addr;
      int unsigned sz;
      sz = $urandom_range(0, 2);
      we = 1'($urandom);
      f3 = {we ? 1'b0 : 1'($urandom), (sz == 2) ? 2'b10 : 2'(sz)};
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(acc_size(f3) - 1);
      run_txn($sformatf("rnd%0d", i), we, addr, $urandom, f3, $urandom,
              $urandom_range(0, 3), 1'($urandom));
    end

    // Asynchronous reset in the middle of a bus wait.
    i_req = 1'b1; i_we = 1'b1; i_addr = 32'h44; i_wdata = 32'hCAFEF00D; i_funct3 = 3'b010;
    @(negedge i_clk);
    i_req = 1'b0;
    @(negedge i_clk);
    check("rst_mid:pre_busy", 32'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge i_clk);
    rst_n = 1'b1;
    @(negedge i_clk);
    run_txn("after_rst", 1'b0, 32'h48, 32'h0, 3'b001, 32'hF00D_1234, 1, 1'b0);

`ifdef ASRV32_DBUS_TIMEOUT_EN
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h80; i_funct3 = 3'b010;
    @(negedge i_clk);
    i_req = 1'b0;
    check("to:stb", 32'(bus.o_stb), 1);
    cyc = 1; got = 1'b0;
    while (!got && cyc < 30) begin
      @(negedge i_clk);
      cyc++;
      if (o_done) got = 1'b1;
    end
    check("to:done_cycle", cyc, 10);
    check("to:bus_err", 32'(o_bus_err), 1);
    check("to:rdata", o_rdata, 0);
    check("to:mis", 32'(o_misaligned), 0);
    @(negedge i_clk);
    bus.i_ack = 1'b1; bus.i_rdata = 32'h5555AAAA;
    check("to:idle_busy", 32'(o_busy), 0);
    @(negedge i_clk);
    bus.i_ack = 1'b0;
    check("to:stray_done", 32'(o_done), 0);
    check("to:stray_busy", 32'(o_busy), 0);
    @(negedge i_clk);
    check("to:stray_done2", 32'(o_done), 0);
`else
    rd = $urandom;
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h80; i_funct3 = 3'b010;
    @(negedge i_clk);
    i_req = 1'b0;
    check("nto:stb", 32'(bus.o_stb), 1);
    got = 1'b0;
    cyc = 0;
    repeat (20) begin
      @(negedge i_clk);
      cyc++;
      if (o_done) got = 1'b1;
    end
    check("nto:no_done", 32'(got), 0);
    check("nto:busy", 32'(o_busy), 1);
    bus.i_ack = 1'b1; bus.i_rdata = rd;
    @(negedge i_clk);
    bus.i_ack = 1'b0;
    check("nto:done", 32'(o_done), 1);
    check("nto:err", 32'(o_bus_err), 0);
    check("nto:rdata", o_rdata, rd);
    @(negedge i_clk);
`endif
    run_txn("final_sb", 1'b1, 32'h31, 32'h000000A5, 3'b000, 32'h0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/asrv32_dbus_master.md
ASRV32_DBUS_MASTER -- requirements
Module: asrv32_dbus_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of wait cycles for i_ack before a bus error.
REQ-002 SHALL have port i_clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_req  input  1  core load/store request, sampled in IDLE only.
REQ-005 SHALL have port i_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port i_addr  input  32  byte address.
REQ-007 SHALL have port i_wdata  input  32  store data, right-aligned.
REQ-008 SHALL have port i_funct3  input  3  access width: [1:0] 00 = byte, 01 = half, 1x = word; [2] = 1 zero-extend (load).
REQ-009 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port o_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port o_rdata  output  32  extended load result, valid while o_done is high.
REQ-012 SHALL have port o_misaligned  output  1  qualifies o_done: access was misaligned and no bus cycle was issued.
REQ-013 SHALL have port o_bus_err  output  1  qualifies o_done: ack timeout.
REQ-014 SHALL have port o_stb  output  1  bus request strobe.
REQ-015 SHALL have port o_we  output  1  bus write enable.
REQ-016 SHALL have port o_addr  output  32  word-aligned bus address ({i_addr[31:2],2'b00}).
REQ-017 SHALL have port o_wdata  output  32  lane-aligned store data.
REQ-018 SHALL have port o_wr_mask  output  4  byte-lane write mask.
REQ-019 SHALL have port i_ack  input  1  responder acknowledge.
REQ-020 SHALL have port i_rdata  input  32  responder read data, valid with i_ack.

Function
REQ-021 SHALL implement FSM IDLE -> STB -> WAIT -> RESP -> IDLE; IDLE -> RESP directly on a misaligned request.
REQ-022 SHALL latch i_we, i_addr, i_wdata and i_funct3 on the IDLE cycle in which i_req=1; i_req SHALL be ignored in all other states.
REQ-023 SHALL treat half accesses with addr[0]=1 and word accesses with addr[1:0]!=0 as misaligned: no o_stb, RESP with o_misaligned=1.
REQ-024 SHALL drive o_stb=1 for exactly one cycle (STB); o_we SHALL equal the latched i_we in STB and be 0 in all other cycles.
REQ-025 SHALL hold o_addr, o_wdata and o_wr_mask stable from STB until leaving WAIT.
REQ-026 SHALL generate stores as follows: byte SHALL replicate wdata[7:0] on all lanes with mask 4'b0001<<addr[1:0]; half SHALL replicate wdata[15:0] with mask 4'b0011<<addr[1:0]; word SHALL use mask 4'b1111.
REQ-027 SHALL register i_rdata when i_ack=1 in WAIT (including an ack arriving in the cycle after STB), then enter RESP.
REQ-028 SHALL form o_rdata by shifting i_rdata right by 8*addr[1:0] and sign- or zero-extending from bit 7 or bit 15 per funct3; stores SHALL return o_rdata=0.
REQ-029 SHALL assert o_done for one cycle in RESP; o_misaligned and o_bus_err SHALL be valid only in that cycle and 0 otherwise.
REQ-030 SHALL ignore an i_ack in IDLE or STB (stale or late ack).
REQ-031 SHALL give a nominal latency of i_req at cycle 0, o_stb at cycle 1, i_ack at cycle 2 and o_done at cycle 3; back-to-back requests SHALL be accepted at cycle 4.

Reset
REQ-032 SHALL, on rst_n=0 at any time including mid-transaction, return to IDLE and clear o_stb, o_we, o_done, o_misaligned, o_bus_err, o_busy, o_rdata, o_addr, o_wdata, o_wr_mask and the timeout counter to 0.

Configuration
REQ-033 SHALL, with ASRV32_DBUS_TIMEOUT_EN defined, count WAIT cycles and, when TIMEOUT_CYCLES cycles elapse without i_ack, enter RESP with o_bus_err=1 and o_rdata=0.
REQ-034 SHALL, without ASRV32_DBUS_TIMEOUT_EN, wait in WAIT indefinitely, drive o_bus_err as constant 0, and include no counter logic.

Verification
REQ-035 SHALL verify LW at 0x10 with a 1-cycle-ack responder returning 0xDEADBEEF -> o_stb at cycle 1, o_done at cycle 3, o_rdata=0xDEADBEEF.
REQ-036 SHALL verify LB at 0x13 and LBU at 0x13 with rdata 0x80FF1234 -> o_rdata=0xFFFFFF80 and 0x00000080 respectively.
REQ-037 SHALL verify SH at 0x22 with wdata 0x0000ABCD -> o_addr=0x20, o_wdata=0xABCDABCD, o_wr_mask=4'b1100, o_we high for exactly one cycle.
REQ-038 SHALL verify LW at 0x05 -> no o_stb, o_done and o_misaligned the next cycle.
REQ-039 SHALL verify, with ASRV32_DBUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, a responder that never acks -> o_done with o_bus_err=1 after 8 WAIT cycles, and a later stray ack is ignored.
REQ-040 SHALL verify rst_n pulsed low during WAIT -> all outputs 0 immediately, and the next request completes normally.
